alu_share_arbiter: RTL and testbench

Shares one 32-bit ALU between two requesters (port 0, port 1) with valid/ready handshakes. Picks a winner, latches its operands and opcode, and drives the ALU operand muxes and select. Waits a fixed ALU latency, captures result and flags, and returns them on a single response channel tagged with the requester id. Sits between the ALU datapath and its two client blocks.

---
 rtl/alu_share_arbiter_pkg.sv | 31 +++
 rtl/alu_share_arbiter_rr_arbiter2.sv | 34 +++
 rtl/alu_share_arbiter.sv | 170 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// ============================================================================
//  Module      : alu_share_arbiter_pkg
//  Description : Shared FSM encoding, ALU flag bit positions and opcodes for
//                the two-port ALU sharing arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_share_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Bit positions inside the {N,Z,C,V} flag nibble
    localparam int C_FLAG_N = 3;
    localparam int C_FLAG_Z = 2;
    localparam int C_FLAG_C = 1;
    localparam int C_FLAG_V = 0;

    localparam logic [3:0] C_OP_ADD = 4'd0;
    localparam logic [3:0] C_OP_SUB = 4'd1;
    localparam logic [3:0] C_OP_AND = 4'd2;
    localparam logic [3:0] C_OP_OR  = 4'd3;
    localparam logic [3:0] C_OP_XOR = 4'd4;

endpackage

`default_nettype wire

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// ============================================================================
//  Module      : alu_share_arbiter_rr_arbiter2
//  Description : Two-input arbiter producing a one-hot grant and winner id.
//                FIXED_PRIO_EN selects fixed priority (port 0 wins ties).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter_rr_arbiter2 (
`ifndef FIXED_PRIO_EN
    input  logic       rr_ptr_i,
`endif
    input  logic       valid0_i,
    input  logic       valid1_i,
    output logic [1:0] grant_o,
    output logic       winner_o
);

    always_comb begin
        grant_o  = 2'b00;
`ifdef FIXED_PRIO_EN
        winner_o = !valid0_i;
`else
        // Ties go to the pointer; a lone requester wins regardless of it
        winner_o = (valid0_i && valid1_i) ? rr_ptr_i : valid1_i;
`endif
        if (valid0_i || valid1_i) begin
            grant_o = winner_o ? 2'b10 : 2'b01;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Shares one ALU between two valid/ready requesters and returns
//                tagged results. Macro FIXED_PRIO_EN: fixed priority, no rr_ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int W       = 32,
    parameter int OPW     = 4,
    parameter int ALU_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic           alu_sel,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_result,
    input  logic [3:0]     alu_flags,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_result,
    output logic [3:0]     rsp_flags
);

    localparam logic [3:0] C_LAT_INIT = 4'(ALU_LAT - 1);

    state_e         state_q, state_d;
    logic           alu_sel_q, alu_sel_d;
    logic [W-1:0]   alu_a_q, alu_a_d;
    logic [W-1:0]   alu_b_q, alu_b_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic [W-1:0]   rsp_result_q, rsp_result_d;
    logic [3:0]     rsp_flags_q, rsp_flags_d;
    logic [3:0]     lat_cnt_q, lat_cnt_d;
`ifndef FIXED_PRIO_EN
    logic           rr_ptr_q, rr_ptr_d;
`endif

    logic [1:0]     w_grant;
    logic           w_winner;
    logic           w_idle;
    logic           w_accept;

    alu_share_arbiter_rr_arbiter2 u_arb (
`ifndef FIXED_PRIO_EN
        .rr_ptr_i (rr_ptr_q),
`endif
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .grant_o  (w_grant),
        .winner_o (w_winner)
    );

    // Readys are also masked while reset is held so nothing is offered then
    assign w_idle     = (state_q == ST_IDLE) && !rst;
    assign req0_ready = w_idle && w_grant[0];
    assign req1_ready = w_idle && w_grant[1];
    assign w_accept   = w_idle && (w_grant != 2'b00);

    always_comb begin
        state_d      = state_q;
        alu_sel_d    = alu_sel_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        lat_cnt_d    = lat_cnt_q;
`ifndef FIXED_PRIO_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    alu_sel_d = w_winner;
                    rsp_id_d  = w_winner;
                    alu_a_d   = w_winner ? req1_a  : req0_a;
                    alu_b_d   = w_winner ? req1_b  : req0_b;
                    alu_op_d  = w_winner ? req1_op : req0_op;
                    lat_cnt_d = C_LAT_INIT;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (lat_cnt_q == 4'd0) begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = alu_flags;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
`ifndef FIXED_PRIO_EN
                    rr_ptr_d    = ~rsp_id_q;
`endif
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            alu_sel_q    <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= 4'd0;
            lat_cnt_q    <= 4'd0;
`ifndef FIXED_PRIO_EN
            rr_ptr_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            alu_sel_q    <= alu_sel_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            lat_cnt_q    <= lat_cnt_d;
`ifndef FIXED_PRIO_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    assign alu_sel    = alu_sel_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
//  Module      : tb_alu_share_arbiter
//  Description : Self-checking bench for alu_share_arbiter (ALU_LAT 1 and 3).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int W     = 32;
    localparam int OPW   = 4;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A (ALU_LAT=1)
    logic v0, rdy0, v1, rdy1, sel, rv, rr, rid;
    logic [W-1:0] ia0, ib0, ia1, ib1, xa, xb, xres, rres;
    logic [OPW-1:0] op0, op1, xop;
    logic [3:0] xflg, rflg;
    // Instance B (ALU_LAT=3)
    logic v0_3, rdy0_3, v1_3, rdy1_3, sel_3, rv_3, rr_3, rid_3;
    logic [W-1:0] ia0_3, ib0_3, ia1_3, ib1_3, xa_3, xb_3, xres_3, rres_3;
    logic [OPW-1:0] op0_3, op1_3, xop_3;
    logic [3:0] xflg_3, rflg_3;

    int n_cmp = 0;
    int n_err = 0;

    // Reference ALU: returns {N,Z,C,V, result}; C on SUB means borrow
    function automatic logic [W+3:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [OPW-1:0] op);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        case (op)
            C_OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            C_OP_SUB: begin
                r = a - b;
                c = (a < b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            C_OP_AND: r = a & b;
            C_OP_OR:  r = a | b;
            C_OP_XOR: r = a ^ b;
            default:  r = a;
        endcase
        return {r[W-1], (r == '0), c, v, r};
    endfunction

    assign {xflg, xres}     = alu_fn(xa, xb, xop);
    assign {xflg_3, xres_3} = alu_fn(xa_3, xb_3, xop_3);

    alu_share_arbiter #(.W(W), .OPW(OPW), .ALU_LAT(LAT_A)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(rdy0), .req0_a(ia0), .req0_b(ib0), .req0_op(op0),
        .req1_valid(v1), .req1_ready(rdy1), .req1_a(ia1), .req1_b(ib1), .req1_op(op1),
        .alu_sel(sel), .alu_a(xa), .alu_b(xb), .alu_op(xop),
        .alu_result(xres), .alu_flags(xflg),
        .rsp_valid(rv), .rsp_ready(rr), .rsp_id(rid), .rsp_result(rres), .rsp_flags(rflg)
    );

    alu_share_arbiter #(.W(W), .OPW(OPW), .ALU_LAT(LAT_B)) u_dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(v0_3), .req0_ready(rdy0_3), .req0_a(ia0_3), .req0_b(ib0_3), .req0_op(op0_3),
        .req1_valid(v1_3), .req1_ready(rdy1_3), .req1_a(ia1_3), .req1_b(ib1_3), .req1_op(op1_3),
        .alu_sel(sel_3), .alu_a(xa_3), .alu_b(xb_3), .alu_op(xop_3),
        .alu_result(xres_3), .alu_flags(xflg_3),
        .rsp_valid(rv_3), .rsp_ready(rr_3), .rsp_id(rid_3), .rsp_result(rres_3), .rsp_flags(rflg_3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v0 = 1'b1; v1 = 1'b1; v0_3 = 1'b1; v1_3 = 1'b1;
        repeat (2) step();
        n_cmp++;
        if ({rv, rid, rflg, sel} !== 7'd0) begin
            n_err++; $display("FAIL reset_ctl: got %b expected 0", {rv, rid, rflg, sel});
        end
        n_cmp++;
        if ({rres, xa, xb, xop} !== '0) begin
            n_err++; $display("FAIL reset_data: got %h/%h/%h/%h expected 0", rres, xa, xb, xop);
        end
        n_cmp++;
        if ({rdy0, rdy1, rdy0_3, rdy1_3} !== 4'b0000) begin
            n_err++; $display("FAIL reset_ready: got %b expected 0000", {rdy0, rdy1, rdy0_3, rdy1_3});
        end
        rst = 1'b0;
        v0 = 1'b0; v1 = 1'b0; v0_3 = 1'b0; v1_3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if ({rv, rdy0, rdy1} !== 3'b000) begin
                n_err++; $display("FAIL idle_quiet: got %b expected 000", {rv, rdy0, rdy1});
            end
        end
        v0 = 1'b1;
        #1;
        n_cmp++;
        if ({rdy0, rdy1} !== 2'b10) begin
            n_err++; $display("FAIL idle_ready: got %b expected 10", {rdy0, rdy1});
        end
        v0 = 1'b0;
        #1;
    endtask

    task automatic test_single_op();
        int cyc;
        rr = 1'b1;
        v0 = 1'b1; ia0 = 32'd5; ib0 = 32'd3; op0 = C_OP_ADD;
        #1;
        n_cmp++;
        if ({rdy0, rdy1} !== 2'b10) begin
            n_err++; $display("FAIL single_ready: got %b expected 10", {rdy0, rdy1});
        end
        step();
        v0 = 1'b0; ia0 = $urandom; ib0 = $urandom; op0 = C_OP_XOR;
        n_cmp++;
        if ({sel, xa, xb, xop} !== {1'b0, 32'd5, 32'd3, C_OP_ADD}) begin
            n_err++; $display("FAIL single_alu_in: got sel=%b a=%h b=%h op=%h expected 0/5/3/0", sel, xa, xb, xop);
        end
        n_cmp++;
        if (rdy0 !== 1'b0) begin
            n_err++; $display("FAIL single_ready_drop: got %b expected 0", rdy0);
        end
        cyc = 1;
        while (!rv && cyc < 20) begin step(); cyc++; end
        n_cmp++;
        if (cyc != LAT_A + 1) begin
            n_err++; $display("FAIL single_latency: got %0d expected %0d", cyc, LAT_A + 1);
        end
        n_cmp++;
        if ({rv, rid, rres, rflg} !== {1'b1, 1'b0, 32'd8, 4'b0000}) begin
            n_err++; $display("FAIL single_rsp: got v=%b id=%b r=%h f=%b expected 1/0/8/0000", rv, rid, rres, rflg);
        end
        step();
        n_cmp++;
        if ({rv, rres} !== {1'b0, 32'd8}) begin
            n_err++; $display("FAIL single_after_hs: got v=%b r=%h expected 0/8", rv, rres);
        end
    endtask

    task automatic test_contention();
        int t;
        logic [W+3:0] exp;
        rst = 1'b1; step(); rst = 1'b0;
        rr = 1'b1;
        v0 = 1'b1; v1 = 1'b1;
        ia1 = 32'd2; ib1 = 32'd7; op1 = C_OP_SUB; op0 = C_OP_ADD;
        for (int k = 0; k < 4; k++) begin
            ia0 = $urandom; ib0 = $urandom;
            #1;
            t = 0;
            while (!(rdy0 || rdy1) && t < 20) begin step(); t++; end
            n_cmp++;
            if ({rdy0, rdy1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_err++; $display("FAIL contention_grant%0d: got %b expected port %0d", k, {rdy0, rdy1}, k % 2);
            end
            exp = (k % 2 == 0) ? alu_fn(ia0, ib0, C_OP_ADD) : alu_fn(32'd2, 32'd7, C_OP_SUB);
            step();
            t = 0;
            while (!rv && t < 20) begin step(); t++; end
            n_cmp++;
            if ({rv, rid, rflg, rres} !== {1'b1, 1'((k % 2)), exp}) begin
                n_err++; $display("FAIL contention_rsp%0d: got v=%b id=%b f=%b r=%h expected id=%0d %h",
                                  k, rv, rid, rflg, rres, k % 2, exp);
            end
            if (k % 2 == 1) begin
                n_cmp++;
                if ({rflg, rres} !== {4'b1010, 32'hFFFF_FFFB}) begin
                    n_err++; $display("FAIL contention_sub: got f=%b r=%h expected 1010/fffffffb", rflg, rres);
                end
            end
            step();
        end
        v0 = 1'b0; v1 = 1'b0;
        #1;
    endtask

    task automatic test_backpressure();
        int t;
        logic [W+3:0] exp;
        logic [W+4:0] snap;
        rr = 1'b0;
        v0 = 1'b1; ia0 = $urandom; ib0 = $urandom; op0 = C_OP_XOR;
        #1;
        t = 0;
        while (!rdy0 && t < 20) begin step(); t++; end
        exp = alu_fn(ia0, ib0, C_OP_XOR);
        step();
        v0 = 1'b0; v1 = 1'b1; ia1 = $urandom; ib1 = $urandom; op1 = C_OP_OR;
        t = 0;
        while (!rv && t < 20) begin step(); t++; end
        n_cmp++;
        if ({rv, rid, rflg, rres} !== {1'b1, 1'b0, exp}) begin
            n_err++; $display("FAIL bp_rsp: got v=%b id=%b %h expected 1/0/%h", rv, rid, {rflg, rres}, exp);
        end
        snap = {rid, rflg, rres};
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({rv, rid, rflg, rres, rdy0, rdy1} !== {1'b1, snap, 2'b00}) begin
                n_err++; $display("FAIL bp_hold%0d: got v=%b %h rdy=%b%b expected 1/%h/00",
                                  i, rv, {rid, rflg, rres}, rdy0, rdy1, snap);
            end
        end
        rr = 1'b1;
        exp = alu_fn(ia1, ib1, C_OP_OR);
        step();
        n_cmp++;
        if ({rv, rdy0, rdy1} !== 3'b001) begin
            n_err++; $display("FAIL bp_release: got v=%b rdy=%b%b expected 0/01", rv, rdy0, rdy1);
        end
        step();
        v1 = 1'b0;
        t = 0;
        while (!rv && t < 20) begin step(); t++; end
        n_cmp++;
        if ({rv, rid, rflg, rres} !== {1'b1, 1'b1, exp}) begin
            n_err++; $display("FAIL bp_next: got v=%b id=%b %h expected 1/1/%h", rv, rid, {rflg, rres}, exp);
        end
        step();
    endtask

    task automatic test_lat3();
        logic [W+3:0]   exp;
        logic [W-1:0]   a, b;
        rr_3 = 1'b0;
        a = $urandom; b = $urandom;
        v1_3 = 1'b1; ia1_3 = a; ib1_3 = b; op1_3 = C_OP_SUB;
        exp = alu_fn(a, b, C_OP_SUB);
        #1;
        n_cmp++;
        if ({rdy0_3, rdy1_3} !== 2'b01) begin
            n_err++; $display("FAIL lat3_ready: got %b expected 01", {rdy0_3, rdy1_3});
        end
        step();
        v1_3 = 1'b0; ia1_3 = ~a; ib1_3 = ~b; op1_3 = C_OP_AND;
        for (int c = 1; c <= LAT_B; c++) begin
            n_cmp++;
            if ({rv_3, sel_3, xa_3, xb_3, xop_3} !== {1'b0, 1'b1, a, b, C_OP_SUB}) begin
                n_err++; $display("FAIL lat3_exec%0d: got v=%b sel=%b a=%h b=%h op=%h expected 0/1/%h/%h/1",
                                  c, rv_3, sel_3, xa_3, xb_3, xop_3, a, b);
            end
            step();
        end
        n_cmp++;
        if ({rv_3, rid_3, rflg_3, rres_3} !== {1'b1, 1'b1, exp}) begin
            n_err++; $display("FAIL lat3_rsp: got v=%b id=%b %h expected 1/1/%h", rv_3, rid_3, {rflg_3, rres_3}, exp);
        end
        rr_3 = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_exec();
        int t;
        int seen;
        logic [W+3:0] exp;
        v0_3 = 1'b1; ia0_3 = $urandom; ib0_3 = $urandom; op0_3 = C_OP_ADD;
        #1;
        step();
        v0_3 = 1'b0;
        step();
        rst = 1'b1; step(); rst = 1'b0;
        n_cmp++;
        if ({rv_3, sel_3, rid_3, xa_3, xb_3, xop_3} !== '0) begin
            n_err++; $display("FAIL midrst_outputs: got v=%b sel=%b id=%b a=%h b=%h op=%h expected 0",
                              rv_3, sel_3, rid_3, xa_3, xb_3, xop_3);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin step(); if (rv_3) seen++; end
        n_cmp++;
        if (seen != 0) begin
            n_err++; $display("FAIL midrst_no_rsp: got %0d valid cycles expected 0", seen);
        end
        v0_3 = 1'b1; v1_3 = 1'b1;
        #1;
        n_cmp++;
        if ({rdy0_3, rdy1_3} !== 2'b10) begin
            n_err++; $display("FAIL midrst_ptr: got %b expected 10", {rdy0_3, rdy1_3});
        end
        v0_3 = 1'b0; ia1_3 = $urandom; ib1_3 = $urandom; op1_3 = C_OP_XOR;
        exp = alu_fn(ia1_3, ib1_3, C_OP_XOR);
        #1;
        n_cmp++;
        if ({rdy0_3, rdy1_3} !== 2'b01) begin
            n_err++; $display("FAIL midrst_req1_ready: got %b expected 01", {rdy0_3, rdy1_3});
        end
        step();
        v1_3 = 1'b0;
        t = 0;
        while (!rv_3 && t < 20) begin step(); t++; end
        n_cmp++;
        if ({rv_3, rid_3, rflg_3, rres_3} !== {1'b1, 1'b1, exp}) begin
            n_err++; $display("FAIL midrst_req1_rsp: got v=%b id=%b %h expected 1/1/%h", rv_3, rid_3, {rflg_3, rres_3}, exp);
        end
        rr_3 = 1'b1;
        step();
    endtask

    // Transaction-level model: idle / busy (countdown) / responding
    task automatic test_random();
        int           mode, cnt;
        logic         ptr, win, e_id;
        logic [W-1:0] e_a, e_b, e_res;
        logic [OPW-1:0] e_op;
        logic [3:0]   e_flg;
        logic [W+3:0] pend;
        logic [1:0]   e_rdy;
        rst = 1'b1; step(); rst = 1'b0;
        mode = 0; cnt = 0; ptr = 1'b0; e_id = 1'b0;
        e_a = '0; e_b = '0; e_op = '0; e_res = '0; e_flg = '0; pend = '0;
        for (int i = 0; i < 400; i++) begin
            n_cmp++;
            if ({rv, rid, sel, rflg, rres, xa, xb, xop} !==
                {(mode == 2), e_id, e_id, e_flg, e_res, e_a, e_b, e_op}) begin
                n_err++; $display("FAIL rand_out@%0d: got v=%b id=%b sel=%b %h a=%h b=%h op=%h expected v=%b id=%b %h a=%h b=%h op=%h",
                                  i, rv, rid, sel, {rflg, rres}, xa, xb, xop,
                                  (mode == 2), e_id, {e_flg, e_res}, e_a, e_b, e_op);
            end
            v0 = ($urandom % 3) != 0; v1 = ($urandom % 3) != 0;
            ia0 = $urandom; ib0 = $urandom; op0 = 4'($urandom % 5);
            ia1 = $urandom; ib1 = $urandom; op1 = 4'($urandom % 5);
            rr = ($urandom % 4) != 0;
            #1;
            win = (v0 && v1) ? ptr : v1;
            e_rdy = 2'b00;
            if (mode == 0 && (v0 || v1)) e_rdy = win ? 2'b01 : 2'b10;
            n_cmp++;
            if ({rdy0, rdy1} !== e_rdy) begin
                n_err++; $display("FAIL rand_ready@%0d: got %b expected %b", i, {rdy0, rdy1}, e_rdy);
            end
            case (mode)
                0: if (v0 || v1) begin
                    e_id = win;
                    e_a  = win ? ia1 : ia0;
                    e_b  = win ? ib1 : ib0;
                    e_op = win ? op1 : op0;
                    pend = alu_fn(e_a, e_b, e_op);
                    mode = 1; cnt = LAT_A;
                end
                1: begin
                    cnt--;
                    if (cnt == 0) begin {e_flg, e_res} = pend; mode = 2; end
                end
                default: if (rr) begin mode = 0; ptr = ~e_id; end
            endcase
            step();
        end
        v0 = 1'b0; v1 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rr = 1'b0; rr_3 = 1'b0;
        v0 = 1'b0; v1 = 1'b0; v0_3 = 1'b0; v1_3 = 1'b0;
        ia0 = '0; ib0 = '0; op0 = '0; ia1 = '0; ib1 = '0; op1 = '0;
        ia0_3 = '0; ib0_3 = '0; op0_3 = '0; ia1_3 = '0; ib1_3 = '0; op1_3 = '0;
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_lat3();
        test_reset_mid_exec();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
